// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
//   CPU_DATA_W : default datapath word width
//   z_state_t  : result-stage occupancy states (EMPTY, HOLD)
package cpu_pkg;

   localparam int unsigned CPU_DATA_W = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } z_state_t;

endpackage

// File: rtl/z_result_stage_if.sv
// Bundle between the ALU result producer / bus sequencer and z_result_stage.
//   in_valid/in_ready      : result handshake
//   in_lo/in_hi/in_wide    : result words and 64-bit indicator
//   read_lo/read_hi        : ZLowout / ZHighout strobes
//   z_bus, z_valid         : bus word and "result held" status
//   flag_z, flag_n, rd_err : captured-result flags and illegal-read pulse
// master = producer/sequencer side, slave = the result stage.
interface z_result_stage_if
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = CPU_DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_lo;
   logic [DATA_W-1:0] in_hi;
   logic              in_wide;
   logic              read_lo;
   logic              read_hi;
   logic [DATA_W-1:0] z_bus;
   logic              z_valid;
   logic              flag_z;
   logic              flag_n;
   logic              rd_err;

   modport master (
      output in_valid, in_lo, in_hi, in_wide, read_lo, read_hi,
      input  in_ready, z_bus, z_valid, flag_z, flag_n, rd_err
   );

   modport slave (
      input  in_valid, in_lo, in_hi, in_wide, read_lo, read_hi,
      output in_ready, z_bus, z_valid, flag_z, flag_n, rd_err
   );
endinterface

// File: rtl/reg32.sv
// Loadable register with asynchronous active-low clear (32 bits by default).
//   clock, clear_n : clock and async active-low clear
//   load           : capture d on the rising edge
//   d, q           : data in / registered data out
module reg32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/z_result_stage.sv
// Z result holding stage: captures an ALU result (32- or 64-bit) and hands
// its halves to the datapath bus on ZLowout/ZHighout strobes.
//   clock, clear_n : clock and async active-low reset
//   zif (slave)    : result handshake, read strobes, bus word, flags, rd_err
module z_result_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = CPU_DATA_W
) (
   input  logic             clock,
   input  logic             clear_n,
   z_result_stage_if.slave  zif
);

   z_state_t          state;
   z_state_t          state_nx;
   logic              lo_pend;
   logic              hi_pend;
   logic [DATA_W-1:0] z_low;
   logic [DATA_W-1:0] z_high;
   logic [DATA_W-1:0] hi_d;
   logic              accept;
   logic              ready_c;
   logic              hi_sel;
   logic              lo_sel;
   logic              bad_rd;
   logic              last_rd;
   logic [DATA_W-1:0] bus_c;

   // Narrow results store a zero high word so the 64-bit zero test is uniform.
   assign hi_d = zif.in_wide ? zif.in_hi : '0;

   reg32 #(.WIDTH(DATA_W)) u_zlow (
      .clock   (clock),
      .clear_n (clear_n),
      .load    (accept),
      .d       (zif.in_lo),
      .q       (z_low)
   );

   reg32 #(.WIDTH(DATA_W)) u_zhigh (
      .clock   (clock),
      .clear_n (clear_n),
      .load    (accept),
      .d       (hi_d),
      .q       (z_high)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      hi_sel   = 1'b0;
      lo_sel   = 1'b0;
      bad_rd   = 1'b0;
      last_rd  = 1'b0;
      ready_c  = 1'b0;
      accept   = 1'b0;
      bus_c    = '0;
      state_nx = state;

      // High strobe wins when both are raised; the low half stays pending.
      hi_sel  = zif.read_hi && hi_pend;
      lo_sel  = !hi_sel && zif.read_lo && lo_pend;
      bad_rd  = (zif.read_hi || zif.read_lo) && !hi_sel && !lo_sel;
      // Consuming the only remaining half frees the stage in the same cycle.
      last_rd = (hi_sel && !lo_pend) || (lo_sel && !hi_pend);

      ready_c = (state == EMPTY) || last_rd;
      accept  = zif.in_valid && ready_c;

      if (hi_sel) begin
         bus_c = z_high;
      end else if (lo_sel) begin
         bus_c = z_low;
      end

      case (state)
         EMPTY:   if (accept) state_nx = HOLD;
         HOLD:    if (accept) state_nx = HOLD;
                  else if (last_rd) state_nx = EMPTY;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         lo_pend    <= 1'b0;
         hi_pend    <= 1'b0;
         zif.flag_z <= 1'b0;
         zif.flag_n <= 1'b0;
         zif.rd_err <= 1'b0;
      end else begin
         zif.rd_err <= bad_rd;
         if (accept) begin
            lo_pend    <= 1'b1;
            hi_pend    <= zif.in_wide;
            zif.flag_z <= (zif.in_lo == '0) && (hi_d == '0);
            zif.flag_n <= zif.in_wide ? zif.in_hi[DATA_W-1] : zif.in_lo[DATA_W-1];
         end else begin
            if (hi_sel) hi_pend <= 1'b0;
            if (lo_sel) lo_pend <= 1'b0;
         end
      end
   end

   assign zif.in_ready = ready_c;
   assign zif.z_bus    = bus_c;
   assign zif.z_valid  = lo_pend || hi_pend;

endmodule

// File: tb/tb_z_result_stage.sv
// Self-checking bench for z_result_stage: expected bus words are queued when
// a result is captured and popped on each legal read.
module tb_z_result_stage;
   import cpu_pkg::*;

   logic clock;
   logic clear_n;
   int unsigned n_cmp;
   int unsigned n_bad;
   logic [31:0] sb[$];

   z_result_stage_if #(.DATA_W(32)) zif ();

   z_result_stage #(.DATA_W(32)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .zif     (zif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present one result; it must be accepted in this cycle.
   task automatic capture(input logic [31:0] lo, input logic [31:0] hi, input logic wide);
      logic ez, en;
      zif.in_valid = 1'b1;
      zif.in_lo    = lo;
      zif.in_hi    = hi;
      zif.in_wide  = wide;
      @(negedge clock);
      check("cap_ready", zif.in_ready, 1);
      step();
      zif.in_valid = 1'b0;
      if (wide) sb.push_back(hi);
      sb.push_back(lo);
      ez = wide ? ({hi, lo} == 64'd0) : (lo == 32'd0);
      en = wide ? hi[31] : lo[31];
      check("cap_valid", zif.z_valid, 1);
      check("cap_flag_z", zif.flag_z, ez);
      check("cap_flag_n", zif.flag_n, en);
   endtask

   // One read cycle; legal reads consume the next scoreboard word.
   task automatic rd(input logic h, input logic l, input logic legal, input logic last);
      logic [31:0] exp;
      zif.read_hi = h;
      zif.read_lo = l;
      @(negedge clock);
      exp = 32'd0;
      if (legal) exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
      check("rd_bus", zif.z_bus, exp);
      if (legal) check("rd_ready", zif.in_ready, last);
      step();
      zif.read_hi = 1'b0;
      zif.read_lo = 1'b0;
      check("rd_err", zif.rd_err, !legal);
      if (legal) check("rd_valid_after", zif.z_valid, !last);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clear_n      = 1'b0;
      zif.in_valid = 1'b0;
      zif.in_lo    = '0;
      zif.in_hi    = '0;
      zif.in_wide  = 1'b0;
      zif.read_lo  = 1'b0;
      zif.read_hi  = 1'b0;
      #12;
      check("rst_ready", zif.in_ready, 1);
      check("rst_valid", zif.z_valid, 0);
      check("rst_bus", zif.z_bus, 0);
      check("rst_flags", {zif.flag_z, zif.flag_n, zif.rd_err}, 0);
      @(negedge clock);
      clear_n = 1'b1;
      step();

      // Narrow negative result
      capture(32'h80000001, 32'hFFFFFFFF, 1'b0);
      check("narrow_ready_hold", zif.in_ready, 0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);
      check("narrow_empty", zif.in_ready, 1);

      // Wide: both strobes take the high half only
      capture(32'h00000000, 32'h00000002, 1'b1);
      rd(1'b1, 1'b1, 1'b1, 1'b0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Back-to-back: new result offered during the final read
      capture(32'h00001234, 32'h0, 1'b0);
      zif.read_lo  = 1'b1;
      zif.in_valid = 1'b1;
      zif.in_lo    = 32'h00005678;
      zif.in_wide  = 1'b0;
      @(negedge clock);
      check("b2b_bus", zif.z_bus, sb.pop_front());
      check("b2b_ready", zif.in_ready, 1);
      step();
      zif.read_lo  = 1'b0;
      zif.in_valid = 1'b0;
      sb.push_back(32'h00005678);
      check("b2b_valid", zif.z_valid, 1);
      check("b2b_flag_z", zif.flag_z, 0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Illegal high read after narrow capture
      capture(32'h000000A5, 32'h12345678, 1'b0);
      rd(1'b1, 1'b0, 1'b0, 1'b0);
      check("illegal_valid", zif.z_valid, 1);
      step();
      check("illegal_err_one_cycle", zif.rd_err, 0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Zero result
      capture(32'h0, 32'hFFFFFFFF, 1'b0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Any read in EMPTY is illegal
      rd(1'b0, 1'b1, 1'b0, 1'b0);

      // in_valid while not ready is ignored
      capture(32'h00000011, 32'h0, 1'b0);
      zif.in_valid = 1'b1;
      zif.in_lo    = 32'h80000000;
      zif.in_wide  = 1'b0;
      step();
      zif.in_valid = 1'b0;
      check("ignore_flag_n", zif.flag_n, 0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Wide negative and wide zero
      capture(32'h00000000, 32'h80000000, 1'b1);
      rd(1'b1, 1'b0, 1'b1, 1'b0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);
      capture(32'h00000000, 32'h00000000, 1'b1);
      rd(1'b1, 1'b1, 1'b1, 1'b0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      // Random mix
      for (int i = 0; i < 16; i++) begin
         logic w;
         w = 1'($urandom_range(0, 1));
         capture($urandom, $urandom, w);
         if (w) begin
            rd(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         end
         rd(1'b0, 1'b1, 1'b1, 1'b1);
      end

      // Reset mid-HOLD after a partial read
      capture(32'hCAFEF00D, 32'h8BADF00D, 1'b1);
      rd(1'b1, 1'b0, 1'b1, 1'b0);
      zif.read_lo = 1'b1;
      #2;
      clear_n = 1'b0;
      #1;
      check("midrst_valid", zif.z_valid, 0);
      check("midrst_ready", zif.in_ready, 1);
      check("midrst_bus", zif.z_bus, 0);
      check("midrst_flags", {zif.flag_z, zif.flag_n}, 0);
      sb.delete();
      zif.read_lo = 1'b0;
      @(negedge clock);
      clear_n = 1'b1;
      step();
      capture(32'h00000042, 32'h0, 1'b0);
      rd(1'b0, 1'b1, 1'b1, 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
